// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: Width CALC cycles per operation, signed results fixed
// up in the last step. Define MULDIV_DIV_EN to build the divide datapath.
module muldiv_unit #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o,
  output logic             div_zero_o
);

  localparam int unsigned CntW = $clog2(Width);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic [Width:0]     acc_hi_q, acc_hi_d;
  logic [Width-1:0]   acc_lo_q, acc_lo_d;
  logic [Width-1:0]   opnd_q, opnd_d;
  logic [Width-1:0]   hi_q, hi_d;
  logic [Width-1:0]   lo_q, lo_d;
  logic               dz_q, dz_d;
`ifdef MULDIV_DIV_EN
  logic [Width-1:0]   a_q, a_d;
  logic               bz_q, bz_d;
  logic               neg_rem_q, neg_rem_d;
  logic [Width:0]     div_shift, div_diff, div_hi_nx;
  logic [Width-1:0]   div_lo_nx;
`endif

  logic               a_neg, b_neg;
  logic [Width-1:0]   a_mag, b_mag;
  logic [Width:0]     mul_sum, mul_hi_nx, step_hi;
  logic [Width-1:0]   mul_lo_nx, step_lo;
  logic [2*Width-1:0] product, prod_res;
  logic [Width-1:0]   res_hi, res_lo;
  logic               res_dz;

  // Signed ops work on magnitudes; the sign fix-up is remembered for the final step.
  always_comb begin
    a_neg = op_i[0] & a_i[Width-1];
    b_neg = op_i[0] & b_i[Width-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
  end

  always_comb begin
    mul_sum   = acc_hi_q + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi_nx = {1'b0, mul_sum[Width:1]};
    mul_lo_nx = {mul_sum[0], acc_lo_q[Width-1:1]};
    step_hi   = mul_hi_nx;
    step_lo   = mul_lo_nx;
`ifdef MULDIV_DIV_EN
    // Restoring step: remainder stays below the divisor, so bit Width of the diff is the borrow.
    div_shift = {acc_hi_q[Width-1:0], acc_lo_q[Width-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_hi_nx = {1'b0, div_diff[Width] ? div_shift[Width-1:0] : div_diff[Width-1:0]};
    div_lo_nx = {acc_lo_q[Width-2:0], ~div_diff[Width]};
    if (div_q) begin
      step_hi = div_hi_nx;
      step_lo = div_lo_nx;
    end
`endif
  end

  always_comb begin
    product  = {mul_hi_nx[Width-1:0], mul_lo_nx};
    prod_res = neg_q ? -product : product;
    res_hi   = prod_res[2*Width-1:Width];
    res_lo   = prod_res[Width-1:0];
    res_dz   = 1'b0;
    if (div_q) begin
`ifdef MULDIV_DIV_EN
      if (bz_q) begin
        res_hi = a_q;
        res_lo = '1;
        res_dz = 1'b1;
      end else begin
        res_hi = neg_rem_q ? -div_hi_nx[Width-1:0] : div_hi_nx[Width-1:0];
        res_lo = neg_q ? -div_lo_nx : div_lo_nx;
      end
`else
      res_hi = '0;
      res_lo = '0;
      res_dz = 1'b1;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    neg_d    = neg_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
`ifdef MULDIV_DIV_EN
    a_d       = a_q;
    bz_d      = bz_q;
    neg_rem_d = neg_rem_q;
`endif
    unique case (state_q)
      StCalc: begin
        if (flush_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q - CntW'(1);
          if (cnt_q == '0) begin
            state_d = StDone;
            cnt_d   = '0;
            hi_d    = res_hi;
            lo_d    = res_lo;
            dz_d    = res_dz;
          end
        end
      end
      default: begin
        state_d = StIdle;
        if (start_i) begin
          state_d  = StCalc;
          cnt_d    = CntW'(Width - 1);
          div_d    = op_i[1];
          neg_d    = a_neg ^ b_neg;
          acc_hi_d = '0;
          // Multiply shifts the multiplier out of acc_lo; divide shifts the dividend out.
          acc_lo_d = op_i[1] ? a_mag : b_mag;
          opnd_d   = op_i[1] ? b_mag : a_mag;
`ifdef MULDIV_DIV_EN
          a_d       = a_i;
          bz_d      = (b_i == '0);
          neg_rem_d = a_neg;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
`ifdef MULDIV_DIV_EN
      a_q       <= '0;
      bz_q      <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      neg_q    <= neg_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
`ifdef MULDIV_DIV_EN
      a_q       <= a_d;
      bz_q      <= bz_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign busy_o     = (state_q == StCalc);
  assign done_o     = (state_q == StDone);
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign div_zero_o = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against a plain-arithmetic reference model.
// Expected divide results follow MULDIV_DIV_EN the same way the design does.
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         start_i = 1'b0;
  logic         flush_i = 1'b0;
  logic [1:0]   op_i = '0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         busy_o, done_o, div_zero_o;
  logic [W-1:0] hi_o, lo_o;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;
  logic         exp_dz = 1'b0;

  muldiv_unit #(.Width(W)) u_dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .op_i       (op_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .div_zero_o (div_zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
  endtask

  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
    logic [63:0] p;
    longint      sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    case (op)
      2'd0: begin
        p = {32'b0, a} * {32'b0, b};
        h = p[63:32];
        l = p[31:0];
      end
      2'd1: begin
        p = sa * sb;
        h = p[63:32];
        l = p[31:0];
      end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == '0) begin
          l  = '1;
          h  = a;
          dz = 1'b1;
        end else if (op == 2'd2) begin
          l = a / b;
          h = a % b;
        end else begin
          q = sa / sb;
          r = sa % sb;
          l = q[31:0];
          h = r[31:0];
        end
`else
        h  = '0;
        l  = '0;
        dz = 1'b1;
`endif
      end
    endcase
  endtask

  // Called at a negedge with the unit in IDLE or DONE; returns at the negedge of the done cycle.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit noise, input bit flush_acc);
    logic [W-1:0] nh, nl;
    logic         nd;
    model(op, a, b, nh, nl, nd);
    op_i    = op;
    a_i     = a;
    b_i     = b;
    start_i = 1'b1;
    flush_i = flush_acc;
    @(negedge clk_i);
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i    = 2'($urandom);
    a_i     = $urandom;
    b_i     = $urandom;
    check("busy_c1", {63'b0, busy_o}, 64'd1);
    for (int k = 2; k <= W + 1; k++) begin
      @(negedge clk_i);
      if (noise && k == 5) start_i = 1'b1;
      if (k == 6) start_i = 1'b0;
      if (k == W) begin
        check("calc_last", {62'b0, busy_o, done_o}, 64'd2);
        check("calc_hold", {hi_o, lo_o}, {exp_hi, exp_lo});
      end
    end
    exp_hi = nh;
    exp_lo = nl;
    exp_dz = nd;
    check("done_cyc", {62'b0, busy_o, done_o}, 64'd1);
    check("hi", {32'b0, hi_o}, {32'b0, exp_hi});
    check("lo", {32'b0, lo_o}, {32'b0, exp_lo});
    check("dz", {63'b0, div_zero_o}, {63'b0, exp_dz});
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int unsigned seen;

  initial begin
    @(negedge clk_i);
    @(negedge clk_i);
    check("rst_ctl", {61'b0, busy_o, done_o, div_zero_o}, 64'd0);
    check("rst_res", {hi_o, lo_o}, 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Directed corner cases, issued back to back.
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op(2'd2, 32'd100, 32'd0, 1'b0, 1'b0);
    run_op(2'd2, 32'd100, 32'd7, 1'b0, 1'b0);
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'd3, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0);
    run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);

    // Idle gap: results and flag hold.
    @(negedge clk_i);
    check("idle_ctl", {62'b0, busy_o, done_o}, 64'd0);
    check("idle_hold", {hi_o, lo_o}, {exp_hi, exp_lo});
    check("idle_dz", {63'b0, div_zero_o}, {63'b0, exp_dz});

    // Flush with a simultaneous start mid-CALC.
    op_i = 2'd0; a_i = 32'd5; b_i = 32'd6; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1; start_i = 1'b1; op_i = 2'd0; a_i = 32'd9; b_i = 32'd9;
    @(negedge clk_i);
    flush_i = 1'b0; start_i = 1'b0;
    check("flush_ctl", {62'b0, busy_o, done_o}, 64'd0);
    check("flush_hold", {hi_o, lo_o}, {exp_hi, exp_lo});
    check("flush_dz", {63'b0, div_zero_o}, {63'b0, exp_dz});
    seen = 0;
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk_i);
      if (busy_o || done_o) seen++;
    end
    check("flush_quiet", 64'(seen), 64'd0);

    // Flush in IDLE and in DONE must not block an accept.
    run_op(2'd0, 32'd5, 32'd6, 1'b0, 1'b1);
    run_op(2'd1, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b1);

    // Randomized traffic with noise starts and idle gaps.
    for (int i = 0; i < 30; i++) begin
      run_op(2'($urandom), pick(), pick(), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    // Asynchronous reset in the middle of a divide.
    op_i = 2'd3; a_i = 32'hFFFF_FF00; b_i = 32'd3; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_ctl", {61'b0, busy_o, done_o, div_zero_o}, 64'd0);
    check("arst_res", {hi_o, lo_o}, 64'd0);
    exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_rst", {62'b0, busy_o, done_o}, 64'd0);
    run_op(2'd0, 32'd2, 32'd3, 1'b0, 1'b0);
    @(negedge clk_i);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
